decode_stage: RTL

- Second pipeline stage. Consumes `pc`/`instruction` from the fetch stage each cycle (already NOOP-padded around BRANCH/JAL).
- Decodes fields, reads a 16x32 register file, sign-extends the immediate and tracks in-flight destination registers with a scoreboard.
- Stalls fetch on RAW/WAW hazards and registers the decoded bundle for the execute stage; writeback writes the register file through a dedicated port.

---
 rtl/decode_stage.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// decode_stage: second pipeline stage.
//
// Splits the fetched instruction into fields and reads the 16x32 register
// file. It also sign-extends the immediate. A busy-bit scoreboard tracks
// destination registers that are still in flight. On a RAW or WAW hazard,
// fetch is stalled and a bubble goes to execute. Otherwise the decoded
// bundle is registered for execute.
//
// Optional build macro: DECODE_WB_BYPASS_EN
//   Defined   - a writeback in the current cycle is forwarded to the operand
//               read, and it counts as already clearing its busy bit.
//   Undefined - reads return the pre-write value, and busy clears at the edge.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-low reset
//   inPc           in   PC of the incoming instruction
//   inInstruction  in   incoming instruction word
//   wbEn           in   writeback write enable
//   wbReg          in   writeback destination index
//   wbData         in   writeback data
//   stall          out  combinational; fetch must hold pc/instruction
//   outPc          out  registered PC
//   outInstruction out  registered instruction (NOOP_WORD for a bubble)
//   outRs1Val      out  registered rs1 operand
//   outRs2Val      out  registered rs2 operand
//   outImm         out  registered sign-extended imm[15:0]
//   outRd          out  registered destination index
//   outRegWrtEn    out  registered; the instruction writes rd
module decode_stage #(
    parameter int               DBITS     = 32,
    parameter int               REG_COUNT = 16,
    parameter logic [DBITS-1:0] NOOP_WORD = 32'h3b000099
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] inPc,
    input  logic [DBITS-1:0] inInstruction,
    input  logic             wbEn,
    input  logic [3:0]       wbReg,
    input  logic [DBITS-1:0] wbData,
    output logic             stall,
    output logic [DBITS-1:0] outPc,
    output logic [DBITS-1:0] outInstruction,
    output logic [DBITS-1:0] outRs1Val,
    output logic [DBITS-1:0] outRs2Val,
    output logic [DBITS-1:0] outImm,
    output logic [3:0]       outRd,
    output logic             outRegWrtEn
);

    localparam logic [3:0] OP_ALUR   = 4'b0000;
    localparam logic [3:0] OP_ALUI   = 4'b1000;
    localparam logic [3:0] OP_CMPR   = 4'b0010;
    localparam logic [3:0] OP_CMPI   = 4'b1010;
    localparam logic [3:0] OP_LOAD   = 4'b1001;
    localparam logic [3:0] OP_STORE  = 4'b0101;
    localparam logic [3:0] OP_BRANCH = 4'b0110;
    localparam logic [3:0] OP_JAL    = 4'b1011;

    logic [DBITS-1:0]     regfile_q [REG_COUNT];
    logic [REG_COUNT-1:0] busy_q, busy_d;

    logic [DBITS-1:0] pc_q, pc_d;
    logic [DBITS-1:0] instr_q, instr_d;
    logic [DBITS-1:0] rs1Val_q, rs1Val_d;
    logic [DBITS-1:0] rs2Val_q, rs2Val_d;
    logic [DBITS-1:0] imm_q, imm_d;
    logic [3:0]       rd_q, rd_d;
    logic             regWrtEn_q, regWrtEn_d;

    logic [3:0]           opcode, rd, rs1, rs2;
    logic [15:0]          imm16;
    logic                 usesRs1, usesRs2, writesRd;
    logic [REG_COUNT-1:0] wbMask, effBusy;
    logic [DBITS-1:0]     rs1Read, rs2Read;
    logic                 hazard, issue;

    // Field extraction and per-opcode source/destination usage. The bubble
    // word carries a real opcode, so it has to be caught by full-word compare
    // before the opcode table is consulted.
    always_comb begin
        opcode   = inInstruction[27:24];
        rd       = inInstruction[23:20];
        rs1      = inInstruction[19:16];
        rs2      = inInstruction[15:12];
        imm16    = inInstruction[15:0];
        usesRs1  = 1'b0;
        usesRs2  = 1'b0;
        writesRd = 1'b0;
        if (inInstruction != NOOP_WORD) begin
            unique case (opcode)
                OP_ALUR, OP_CMPR: begin
                    usesRs1  = 1'b1;
                    usesRs2  = 1'b1;
                    writesRd = 1'b1;
                end
                OP_ALUI, OP_CMPI, OP_LOAD, OP_JAL: begin
                    usesRs1  = 1'b1;
                    writesRd = 1'b1;
                end
                OP_STORE, OP_BRANCH: begin
                    usesRs1  = 1'b1;
                    usesRs2  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Operand read and hazard detection. With the bypass build, a writeback
    // landing this cycle is visible to the read and no longer counts as busy.
    always_comb begin
        wbMask = wbEn ? (REG_COUNT'(1) << wbReg) : '0;
`ifdef DECODE_WB_BYPASS_EN
        effBusy = busy_q & ~wbMask;
        rs1Read = (wbEn && usesRs1 && (wbReg == rs1)) ? wbData : regfile_q[rs1];
        rs2Read = (wbEn && usesRs2 && (wbReg == rs2)) ? wbData : regfile_q[rs2];
`else
        effBusy = busy_q;
        rs1Read = regfile_q[rs1];
        rs2Read = regfile_q[rs2];
`endif
        hazard = (usesRs1 & effBusy[rs1]) | (usesRs2 & effBusy[rs2]) |
                 (writesRd & effBusy[rd]);
        issue  = (usesRs1 | writesRd) & ~hazard;
        stall  = reset & hazard;
    end

    // Next output bundle: a bubble unless an instruction issues. Writeback
    // clears its busy bit first, so an issue to the same rd leaves it set.
    always_comb begin
        pc_d       = inPc;
        instr_d    = NOOP_WORD;
        rs1Val_d   = '0;
        rs2Val_d   = '0;
        imm_d      = '0;
        rd_d       = '0;
        regWrtEn_d = 1'b0;
        busy_d     = busy_q & ~wbMask;
        if (issue) begin
            instr_d    = inInstruction;
            rs1Val_d   = rs1Read;
            rs2Val_d   = rs2Read;
            imm_d      = {{(DBITS-16){imm16[15]}}, imm16};
            rd_d       = rd;
            regWrtEn_d = writesRd;
            if (writesRd) begin
                busy_d[rd] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= '0;
            instr_q    <= NOOP_WORD;
            rs1Val_q   <= '0;
            rs2Val_q   <= '0;
            imm_q      <= '0;
            rd_q       <= '0;
            regWrtEn_q <= 1'b0;
            busy_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            rs1Val_q   <= rs1Val_d;
            rs2Val_q   <= rs2Val_d;
            imm_q      <= imm_d;
            rd_q       <= rd_d;
            regWrtEn_q <= regWrtEn_d;
            busy_q     <= busy_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regfile_q[i] <= '0;
            end
        end else if (wbEn) begin
            regfile_q[wbReg] <= wbData;
        end
    end

    assign outPc          = pc_q;
    assign outInstruction = instr_q;
    assign outRs1Val      = rs1Val_q;
    assign outRs2Val      = rs2Val_q;
    assign outImm         = imm_q;
    assign outRd          = rd_q;
    assign outRegWrtEn    = regWrtEn_q;

endmodule
